// File: rtl/lsm_pkg.sv
// Shared definitions for the LDM/STM sequencer: FSM states, {P,U} addressing modes and
// address arithmetic helpers.
package lsm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } lsm_state_e;

  // Encoded as {P, U}, so bit 0 is the up/down direction.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } lsm_mode_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [31:0] start_addr(input lsm_mode_e mode, input logic [31:0] b,
                                             input logic [4:0] n);
    logic [31:0] span;
    logic [31:0] a;
    span = {25'd0, n, 2'b00};
    case (mode)
      MODE_IA: a = b;
      MODE_IB: a = b + 32'd4;
      MODE_DA: a = b - span + 32'd4;
      MODE_DB: a = b - span;
      default: a = b;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] final_base(input lsm_mode_e mode, input logic [31:0] b,
                                             input logic [4:0] n);
    logic [31:0] span;
    span = {25'd0, n, 2'b00};
    return mode[0] ? (b + span) : (b - span);
  endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Memory-side beat handshake of the LDM/STM sequencer, including the register-bank
// index/load strobe that accompanies each beat.
interface lsm_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] addr;
  logic [3:0]  reg_num;
  logic        ld_reg;
  logic        mem_ready;

  modport master (output mem_req, mem_we, addr, reg_num, ld_reg, input mem_ready);
  modport slave  (input mem_req, mem_we, addr, reg_num, ld_reg, output mem_ready);
endinterface

// File: rtl/lsm_priority_enc.sv
// 16-bit lowest-set-bit encoder; picks the next register of an LDM/STM list.
module lsm_priority_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan downward so the lowest set bit is the final, winning assignment.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = vec[i] ? 4'(i) : idx;
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: one memory beat per listed register, lowest register at lowest address.
// Build macro LSM_WRITEBACK_EN enables the base writeback state (W bit); otherwise W is ignored.
module lsm_sequencer
  import lsm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic [31:0]     base,
  output logic            busy,
  output logic            wb_en,
  output logic [31:0]     wb_value,
  output logic            done,
  lsm_sequencer_if.master mem
);

  lsm_state_e  state_r, state_next_s;
  lsm_mode_e   mode_r, mode_next_s;
  logic [15:0] list_r, list_next_s;
  logic [4:0]  cnt_r, cnt_next_s;
  logic [4:0]  n_s;
  logic [31:0] base_r, base_next_s;
  logic [31:0] addr_r, addr_next_s;
  logic        l_r, l_next_s;
  logic        busy_r, mem_req_r, mem_we_r, done_r;
  logic [3:0]  reg_num_r, enc_idx_s;
  logic        enc_valid_unused_s;
  logic        unused_ir_s;
`ifdef LSM_WRITEBACK_EN
  logic        w_r, w_next_s;
  logic [31:0] wbv_r, wbv_next_s;
  logic        wb_en_r;
`endif

  assign n_s = popcount16(list_r);

  lsm_priority_enc u_enc (
    .vec   (list_next_s),
    .idx   (enc_idx_s),
    .valid (enc_valid_unused_s)
  );

  // Next-state and datapath update; the operation works only from values captured at start.
  always_comb begin
    state_next_s = state_r;
    mode_next_s  = mode_r;
    list_next_s  = list_r;
    cnt_next_s   = cnt_r;
    base_next_s  = base_r;
    addr_next_s  = addr_r;
    l_next_s     = l_r;
`ifdef LSM_WRITEBACK_EN
    w_next_s     = w_r;
    wbv_next_s   = wbv_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SETUP;
          list_next_s  = ir[15:0];
          mode_next_s  = lsm_mode_e'({ir[24], ir[23]});
          l_next_s     = ir[20];
          base_next_s  = base;
`ifdef LSM_WRITEBACK_EN
          w_next_s     = ir[21];
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        cnt_next_s  = n_s;
        addr_next_s = start_addr(mode_r, base_r, n_s);
`ifdef LSM_WRITEBACK_EN
        wbv_next_s  = final_base(mode_r, base_r, n_s);
`endif
        if (n_s == 5'd0) begin
          state_next_s = DONE;
        end else begin
          state_next_s = XFER;
        end
      end
      XFER: begin
        if (mem.mem_ready) begin
          list_next_s = list_r & ~(16'd1 << reg_num_r);
          cnt_next_s  = cnt_r - 5'd1;
          addr_next_s = addr_r + 32'd4;
          if (cnt_r == 5'd1) begin
`ifdef LSM_WRITEBACK_EN
            state_next_s = w_r ? WB : DONE;
`else
            state_next_s = DONE;
`endif
          end else begin
            state_next_s = XFER;
          end
        end else begin
          state_next_s = XFER;
        end
      end
`ifdef LSM_WRITEBACK_EN
      WB:      state_next_s = DONE;
`endif
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= MODE_DA;
      list_r    <= 16'd0;
      cnt_r     <= 5'd0;
      base_r    <= 32'd0;
      addr_r    <= 32'd0;
      l_r       <= 1'b0;
      busy_r    <= 1'b0;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      reg_num_r <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      mode_r    <= mode_next_s;
      list_r    <= list_next_s;
      cnt_r     <= cnt_next_s;
      base_r    <= base_next_s;
      addr_r    <= addr_next_s;
      l_r       <= l_next_s;
      busy_r    <= (state_next_s != IDLE);
      mem_req_r <= (state_next_s == XFER);
      mem_we_r  <= (state_next_s == XFER) & ~l_next_s;
      reg_num_r <= (state_next_s == XFER) ? enc_idx_s : 4'd0;
      done_r    <= (state_next_s == DONE);
    end
  end

`ifdef LSM_WRITEBACK_EN
  // Writeback bookkeeping: W flag, final base value and the one-cycle write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_r     <= 1'b0;
      wbv_r   <= 32'd0;
      wb_en_r <= 1'b0;
    end else begin
      w_r     <= w_next_s;
      wbv_r   <= wbv_next_s;
      wb_en_r <= (state_next_s == WB);
    end
  end

  assign wb_en       = wb_en_r;
  assign wb_value    = wbv_r;
  assign unused_ir_s = ^{ir[31:25], ir[22], ir[19:16]};
`else
  assign wb_en       = 1'b0;
  assign wb_value    = 32'd0;
  assign unused_ir_s = ^{ir[31:25], ir[22:21], ir[19:16]};
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign mem.mem_req = mem_req_r;
  assign mem.mem_we  = mem_we_r;
  assign mem.addr    = addr_r;
  assign mem.reg_num = reg_num_r;
  // Load strobe must coincide with the completing beat, so it follows mem_ready directly.
  assign mem.ld_reg  = mem_req_r & mem.mem_ready & l_r;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed-vector bench for lsm_sequencer: table of LDM/STM operations plus hand-written
// stall, reset-abort and start-while-busy sequences.
module tb_lsm_sequencer;

`ifdef LSM_WRITEBACK_EN
  localparam logic WB_BUILD = 1'b1;
`else
  localparam logic WB_BUILD = 1'b0;
`endif
  localparam int NV = 7;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] base;
    logic [31:0] addr0;
    int          n;
    logic [31:0] wbv;
    int          stall;
    logic        poke;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] ir;
  logic [31:0] base;
  logic        busy;
  logic        wb_en;
  logic [31:0] wb_value;
  logic        done;
  int          checks;
  int          errors;
  vec_t        vecs [NV];

  lsm_sequencer_if mif ();

  lsm_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ir       (ir),
    .base     (base),
    .busy     (busy),
    .wb_en    (wb_en),
    .wb_value (wb_value),
    .done     (done),
    .mem      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [15:0] l);
    for (int i = 0; i < 16; i++) begin
      if (l[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},     {31'd0, busy},         32'd0);
    chk({tag, ".mem_req"},  {31'd0, mif.mem_req},  32'd0);
    chk({tag, ".mem_we"},   {31'd0, mif.mem_we},   32'd0);
    chk({tag, ".addr"},     mif.addr,              32'd0);
    chk({tag, ".reg_num"},  {28'd0, mif.reg_num},  32'd0);
    chk({tag, ".ld_reg"},   {31'd0, mif.ld_reg},   32'd0);
    chk({tag, ".wb_en"},    {31'd0, wb_en},        32'd0);
    chk({tag, ".wb_value"}, wb_value,              32'd0);
    chk({tag, ".done"},     {31'd0, done},         32'd0);
  endtask

  // One operation, cycle numbering: the start cycle is cycle 1.
  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] lst;
    logic        exp_l;
    logic        exp_w;
    int          exp_done;
    int          beat, ld_cnt, wb_cnt, req_cyc, stall_left, cyc;
    bit          seen_done;
    lst        = v.ir[15:0];
    exp_l      = v.ir[20];
    exp_w      = v.ir[21] & WB_BUILD & (v.n != 0);
    exp_done   = 3 + v.n + int'(exp_w) + v.stall;
    beat       = 0;
    ld_cnt     = 0;
    wb_cnt     = 0;
    req_cyc    = 0;
    stall_left = v.stall;
    seen_done  = 1'b0;
    ir    = v.ir;
    base  = v.base;
    start = 1'b1;
    mif.mem_ready = 1'b1;
    @(posedge clk); #1;
    ir    = ~v.ir;
    base  = v.base ^ 32'h5A5A_0F0F;
    cyc   = 2;
    while (!seen_done && cyc < 80) begin
      start = (v.poke && cyc == 4) ? 1'b1 : 1'b0;
      mif.mem_ready = !(mif.mem_req && stall_left > 0);
      if (mif.mem_req && stall_left > 0) stall_left--;
      #1;
      if (mif.ld_reg) ld_cnt++;
      if (mif.mem_req) begin
        req_cyc++;
        chk({tag, ".addr"},    mif.addr, v.addr0 + 32'(beat * 4));
        chk({tag, ".reg_num"}, {28'd0, mif.reg_num}, 32'(lowest(lst)));
        chk({tag, ".mem_we"},  {31'd0, mif.mem_we}, {31'd0, ~exp_l});
        chk({tag, ".ld_reg"},  {31'd0, mif.ld_reg}, {31'd0, exp_l & mif.mem_ready});
        if (mif.mem_ready) begin
          lst[lowest(lst)] = 1'b0;
          beat++;
        end
      end
      if (wb_en) begin
        wb_cnt++;
        chk({tag, ".wb_value_at_wb"}, wb_value, v.wbv);
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, ".done_cycle"}, 32'(cyc), 32'(exp_done));
        chk({tag, ".wb_value"}, wb_value, WB_BUILD ? v.wbv : 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, {31'd0, seen_done}, 32'd1);
    chk({tag, ".beats"},     32'(beat), 32'(v.n));
    chk({tag, ".req_cycles"}, 32'(req_cyc), 32'(v.n + v.stall));
    chk({tag, ".ld_pulses"}, 32'(ld_cnt), exp_l ? 32'(v.n) : 32'd0);
    chk({tag, ".wb_pulses"}, 32'(wb_cnt), {31'd0, exp_w});
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".idle_done"}, {31'd0, done}, 32'd0);
  endtask

  // Abort an LDM IA of r0-r3 during its second beat, then confirm the block stays quiet.
  task automatic reset_midop();
    int nb;
    int noisy;
    nb    = 0;
    noisy = 0;
    ir    = 32'h00B0_000F;
    base  = 32'h0000_0100;
    start = 1'b1;
    mif.mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && nb < 2; k++) begin
      @(posedge clk); #1;
      if (mif.mem_req) nb++;
    end
    chk("rst_mid.reached_beat2", 32'(nb), 32'd2);
    chk("rst_mid.beat2_reg", {28'd0, mif.reg_num}, 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy || mif.mem_req || mif.ld_reg || wb_en || done) noisy++;
    end
    chk("rst_mid.quiet_after", 32'(noisy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    ir     = 32'd0;
    base   = 32'd0;
    mif.mem_ready = 1'b0;

    // STM IA r0-r3, W=1
    vecs[0] = '{ir: 32'h00A0_000F, base: 32'h0000_0100, addr0: 32'h0000_0100, n: 4,
                wbv: 32'h0000_0110, stall: 0, poke: 1'b0};
    // LDM DB r0,r15, W=0
    vecs[1] = '{ir: 32'h0110_8001, base: 32'h0000_0200, addr0: 32'h0000_01F8, n: 2,
                wbv: 32'h0000_01F8, stall: 0, poke: 1'b0};
    // LDM IB r4 with three wait cycles
    vecs[2] = '{ir: 32'h0190_0010, base: 32'h0000_0100, addr0: 32'h0000_0104, n: 1,
                wbv: 32'h0000_0104, stall: 3, poke: 1'b0};
    // STM DA r0-r2 wrapping below zero, W=1
    vecs[3] = '{ir: 32'h0020_0007, base: 32'h0000_0004, addr0: 32'hFFFF_FFFC, n: 3,
                wbv: 32'hFFFF_FFF8, stall: 0, poke: 1'b0};
    // LDM IA empty list, W=1
    vecs[4] = '{ir: 32'h00B0_0000, base: 32'h0000_0300, addr0: 32'h0000_0300, n: 0,
                wbv: 32'h0000_0300, stall: 0, poke: 1'b0};
    // LDM IA sparse list, W=1, start pulsed while busy
    vecs[5] = '{ir: 32'h00B0_A5A5, base: 32'h0000_1000, addr0: 32'h0000_1000, n: 8,
                wbv: 32'h0000_1020, stall: 0, poke: 1'b1};
    // STM DB r8 from base 0, W=1
    vecs[6] = '{ir: 32'h0120_0100, base: 32'h0000_0000, addr0: 32'hFFFF_FFFC, n: 1,
                wbv: 32'hFFFF_FFFC, stall: 0, poke: 1'b0};

    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    reset_midop();
    run_vec(vecs[1], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
